d_ff_bank_write_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit bank of clock-enabled, synchronous-reset D flip-flops between N requesters. It sequences every access as a single-cycle ce pulse (write) or sreset pulse (clear), followed by a programmable cooldown. It sits between the requesting FSMs and the flip-flop bank, and is the only driver of the bank's D, ce and reset inputs.

---
 rtl/d_ff_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/d_ff_bank_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_d_ff_bank_write_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/d_ff_arb_pkg.sv
// Shared types and widths for the flip-flop bank write arbiter.
package d_ff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACKW,
        COOL
    } state_t;

    localparam int COOL_CNT_W = 4;
    localparam int STATS_W    = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above pointer, wrapping at N-1.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    output logic [PW-1:0] winner,
    output logic [N-1:0]  onehot,
    output logic          any_req
);

    assign any_req = |req;

    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(pointer) + i) % N;
            if (!found && req[idx[PW-1:0]]) begin
                found                 = 1'b1;
                winner                = idx[PW-1:0];
                onehot[idx[PW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/d_ff_bank_write_arbiter.sv
// Round-robin arbiter sequencing write/clear accesses to one shared D flip-flop bank.
// Optional access counter (access_count, stats_clr) is built when D_FF_ARB_STATS_EN is defined.
module d_ff_bank_write_arbiter
    import d_ff_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     clr,
    input  logic [N*W-1:0]   wdata,
    input  logic [W-1:0]     bank_q,
    output logic [W-1:0]     bank_d,
    output logic             bank_ce,
    output logic             bank_sreset,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     rdata
`ifdef D_FF_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [STATS_W-1:0] access_count
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [COOL_CNT_W-1:0] COOL_LAST =
        COOL_CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t                state, state_nx;
    logic [PW-1:0]         ptr, ptr_nx;
    logic [COOL_CNT_W-1:0] cool_cnt, cool_cnt_nx;
    logic [N-1:0]          gnt_nx, ack_nx;
    logic                  ce_nx, sreset_nx;
    logic [W-1:0]          d_nx, rdata_nx;

    logic [PW-1:0]         pick_winner;
    logic [N-1:0]          pick_onehot;
    logic                  pick_any;
    logic [W-1:0]          pick_data;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req     (req),
        .pointer (ptr),
        .winner  (pick_winner),
        .onehot  (pick_onehot),
        .any_req (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_winner == PW'(i)) begin
                pick_data = wdata[i*W +: W];
            end
        end
    end

    // Every output is a register; this block only computes their next values.
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        cool_cnt_nx = cool_cnt;
        gnt_nx      = gnt;
        ack_nx      = '0;
        ce_nx       = 1'b0;
        sreset_nx   = 1'b0;
        d_nx        = bank_d;
        rdata_nx    = rdata;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = ACCESS;
                    gnt_nx   = pick_onehot;
                    ptr_nx   = (pick_winner == LAST_IDX) ? '0 : pick_winner + 1'b1;
                    if (|(clr & pick_onehot)) begin
                        sreset_nx = 1'b1;
                        d_nx      = '0;
                    end else begin
                        ce_nx = 1'b1;
                        d_nx  = pick_data;
                    end
                end
            end
            ACCESS: state_nx = ACKW;
            ACKW: begin
                rdata_nx    = bank_q;
                ack_nx      = gnt;
                gnt_nx      = '0;
                cool_cnt_nx = '0;
                state_nx    = (HOLD_CYCLES == 0) ? IDLE : COOL;
            end
            COOL: begin
                if (cool_cnt == COOL_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cool_cnt_nx = cool_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cool_cnt    <= '0;
            gnt         <= '0;
            ack         <= '0;
            bank_ce     <= 1'b0;
            bank_sreset <= 1'b0;
            bank_d      <= '0;
            rdata       <= '0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cool_cnt    <= cool_cnt_nx;
            gnt         <= gnt_nx;
            ack         <= ack_nx;
            bank_ce     <= ce_nx;
            bank_sreset <= sreset_nx;
            bank_d      <= d_nx;
            rdata       <= rdata_nx;
        end
    end

`ifdef D_FF_ARB_STATS_EN
    // Counts on the edge that raises ack; clear wins over increment.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            access_count <= '0;
        end else if (stats_clr) begin
            access_count <= '0;
        end else if (state == ACKW && access_count != '1) begin
            access_count <= access_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_d_ff_bank_write_arbiter.sv
// Self-checking bench for d_ff_bank_write_arbiter (N=4, W=8, HOLD_CYCLES=1) with a behavioural bank.
module tb_d_ff_bank_write_arbiter;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req, clr;
    logic [31:0] wdata;
    logic [7:0]  bank_q = 8'h00;
    logic [7:0]  bank_d;
    logic        bank_ce, bank_sreset;
    logic [3:0]  gnt, ack;
    logic [7:0]  rdata;
`ifdef D_FF_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] access_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  clr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        ce;
        logic        sr;
        logic [7:0]  d;
        logic [7:0]  rdata;
    } vec_t;

    d_ff_bank_write_arbiter #(.N(4), .W(8), .HOLD_CYCLES(1)) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .req         (req),
        .clr         (clr),
        .wdata       (wdata),
        .bank_q      (bank_q),
        .bank_d      (bank_d),
        .bank_ce     (bank_ce),
        .bank_sreset (bank_sreset),
        .gnt         (gnt),
        .ack         (ack),
        .rdata       (rdata)
`ifdef D_FF_ARB_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .access_count(access_count)
`endif
    );

    always #5 Clk = ~Clk;

    // Shared flip-flop bank: synchronous reset beats clock enable.
    always @(posedge Clk) begin
        if (bank_sreset) bank_q <= 8'h00;
        else if (bank_ce) bank_q <= bank_d;
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c, input logic [31:0] w);
        req   = r;
        clr   = c;
        wdata = w;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, "_gnt"}, {28'd0, gnt}, {28'd0, v.gnt});
        checkOutput({tag, "_ack"}, {28'd0, ack}, {28'd0, v.ack});
        checkOutput({tag, "_ce"}, {31'd0, bank_ce}, {31'd0, v.ce});
        checkOutput({tag, "_sreset"}, {31'd0, bank_sreset}, {31'd0, v.sr});
        checkOutput({tag, "_d"}, {24'd0, bank_d}, {24'd0, v.d});
        checkOutput({tag, "_rdata"}, {24'd0, rdata}, {24'd0, v.rdata});
    endtask

`ifdef D_FF_ARB_STATS_EN
    task automatic doAccess(input int n, input logic [7:0] data);
        applyStimulus(4'b0001, 4'b0000, {24'd0, data});
        tick();
        tick();
        tick();
        checkOutput($sformatf("stats_ack%0d", n), {28'd0, ack}, 32'h1);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[12];
        int         gcount;
        logic [3:0] prev_gnt;
        logic [3:0] gnt_seen[5];
        int         gnt_cyc[5];
        logic       both_hi;

        vecs[0]  = '{4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'hA5, 8'h00};
        vecs[1]  = '{4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'hA5, 8'h00};
        vecs[2]  = '{4'b0001, 4'b0000, 32'h000000A5, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'hA5, 8'hA5};
        vecs[3]  = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5, 8'hA5};
        vecs[4]  = '{4'b0100, 4'b0000, 32'h003C0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'h3C, 8'hA5};
        vecs[5]  = '{4'b0100, 4'b0000, 32'h003C0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'h3C, 8'hA5};
        vecs[6]  = '{4'b0100, 4'b0000, 32'h003C0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'h3C, 8'h3C};
        vecs[7]  = '{4'b0100, 4'b0100, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h3C, 8'h3C};
        vecs[8]  = '{4'b0100, 4'b0100, 32'h00000000, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h00, 8'h3C};
        vecs[9]  = '{4'b0100, 4'b0100, 32'h00000000, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h3C};
        vecs[10] = '{4'b0100, 4'b0100, 32'h00000000, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[11] = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00};

        reset_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 32'h0);
`ifdef D_FF_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #12;
        checkAll("reset", '{4'b0, 4'b0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00});
        @(negedge Clk);
        reset_n = 1'b1;

        // Single write then clear, cycle by cycle.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].req, vecs[i].clr, vecs[i].wdata);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i]);
        end

        // Requester 0 wins from pointer 3, then withdraws; its write must still finish.
        applyStimulus(4'b0011, 4'b0000, 32'h00002211);
        tick();
        checkOutput("wd_gnt0", {28'd0, gnt}, 32'h1);
        checkOutput("wd_d0", {24'd0, bank_d}, 32'h11);
        applyStimulus(4'b0010, 4'b0000, 32'h00002200);
        tick();
        tick();
        checkOutput("wd_ack0", {28'd0, ack}, 32'h1);
        checkOutput("wd_rdata0", {24'd0, rdata}, 32'h11);
        tick();
        tick();
        checkOutput("wd_gnt1", {28'd0, gnt}, 32'h2);
        checkOutput("wd_d1", {24'd0, bank_d}, 32'h22);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        tick();
        tick();
        checkOutput("wd_ack1", {28'd0, ack}, 32'h2);
        checkOutput("wd_rdata1", {24'd0, rdata}, 32'h22);
        tick();

        // Abort an access with an async reset pulse; the aborted grant moved the pointer to 2.
        applyStimulus(4'b0010, 4'b0000, 32'h00007700);
        tick();
        checkOutput("ar_gnt_pre", {28'd0, gnt}, 32'h2);
        checkOutput("ar_ce_pre", {31'd0, bank_ce}, 32'h1);
        #1 reset_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        checkOutput("ar_gnt", {28'd0, gnt}, 32'h0);
        checkOutput("ar_ce", {31'd0, bank_ce}, 32'h0);
        checkOutput("ar_sreset", {31'd0, bank_sreset}, 32'h0);
        checkOutput("ar_ack", {28'd0, ack}, 32'h0);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("ar_noack%0d", i), {28'd0, ack}, 32'h0);
        end
        checkOutput("ar_bank_kept", {24'd0, bank_q}, 32'h22);

        // All four requesting: order 0,1,2,3,0 from the restarted pointer, 4 cycles apart.
        applyStimulus(4'b1111, 4'b0000, 32'h44332211);
        gcount   = 0;
        prev_gnt = 4'b0000;
        both_hi  = 1'b0;
        for (int cyc = 0; cyc < 40 && gcount < 5; cyc++) begin
            tick();
            if (bank_ce && bank_sreset) both_hi = 1'b1;
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                gnt_seen[gcount] = gnt;
                gnt_cyc[gcount]  = cyc;
                gcount++;
            end
            prev_gnt = gnt;
        end
        checkOutput("rr_count", gcount, 5);
        for (int k = 0; k < gcount; k++) begin
            checkOutput($sformatf("rr_grant%0d", k), {28'd0, gnt_seen[k]}, 32'd1 << (k % 4));
            if (k > 0) checkOutput($sformatf("rr_spacing%0d", k), gnt_cyc[k] - gnt_cyc[k-1], 4);
        end
        checkOutput("ce_sreset_excl", {31'd0, both_hi}, 32'h0);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("settle_gnt", {28'd0, gnt}, 32'h0);

`ifdef D_FF_ARB_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checkOutput("stats_zero", {16'd0, access_count}, 32'h0);
        for (int n = 0; n < 5; n++) doAccess(n, 8'(8'h10 + n));
        checkOutput("stats_five", {16'd0, access_count}, 32'h5);
        applyStimulus(4'b0001, 4'b0000, 32'h000000EE);
        tick();
        tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checkOutput("stats_clr_ack", {28'd0, ack}, 32'h1);
        checkOutput("stats_clr_prio", {16'd0, access_count}, 32'h0);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
